// File: rtl/tlc_pkg.sv
// Shared encodings for the intersection phase sequencer, lamp drivers and monitors.
package tlc_pkg;
   localparam logic [2:0] S_GREEN   = 3'd0;
   localparam logic [2:0] S_CLEAR   = 3'd1;
   localparam logic [2:0] S_PED     = 3'd2;
   localparam logic [2:0] S_SERVICE = 3'd3;
   // Target-select flag held alongside the next phase index: 1 = go to the walk phase
   localparam logic NXT_PED = 1'b1;
   localparam int   CNT_W   = 8;
endpackage

// File: rtl/phase_sequencer_clear_timer.sv
// Tick-driven loadable down-counter; load wins over tick, holds at zero.
module clear_timer
   import tlc_pkg::*;
#(
   parameter int W = CNT_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         tick,
   output logic         last,
   output logic         zero
);
   logic [W-1:0] count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                       count <= '0;
      else if (load)                  count <= load_val;
      else if (tick && count != '0)   count <= count - 1'b1;
   end

   assign last = (count == W'(1));
   assign zero = (count == '0);
endmodule

// File: rtl/phase_sequencer.sv
// Traffic-intersection phase sequencer: vehicle phases in order, all-red clearance
// between them, latched pedestrian phase, and a service-mode override.
module phase_sequencer
   import tlc_pkg::*;
#(
   parameter int N_PHASES    = 4,
   parameter int CLEAR_TICKS = 3,
   parameter int PH_W        = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                service,
   input  logic                ped_button,
   input  logic [N_PHASES-1:0] phase_done,
   input  logic                ped_done,
   output logic [PH_W-1:0]     phase_idx,
   output logic [N_PHASES-1:0] green,
   output logic                ped_green,
   output logic                all_red,
   output logic                service_mode,
   output logic                ped_pending
);
   localparam logic [PH_W-1:0]     LAST_IDX = PH_W'(N_PHASES - 1);
   localparam logic [CNT_W-1:0]    CLR_LEN  = CNT_W'(CLEAR_TICKS);
   localparam logic [N_PHASES-1:0] ONE      = N_PHASES'(1);

   logic [2:0]      state, state_d;
   logic [PH_W-1:0] cur, cur_d, nxt_idx, nxt_idx_d;
   logic            nxt_ped, nxt_ped_d;
   logic            pend_d;
   logic            clr_load, clr_last, clr_zero;

   always_comb begin
      state_d   = state;
      cur_d     = cur;
      nxt_idx_d = nxt_idx;
      nxt_ped_d = nxt_ped;
      if (service) begin
         state_d = S_SERVICE;
      end else begin
         case (state)
            S_GREEN: if (phase_done[cur]) begin
               state_d = S_CLEAR;
               if (cur < LAST_IDX) begin
                  nxt_idx_d = cur + 1'b1;
                  nxt_ped_d = ~NXT_PED;
               end else begin
                  nxt_idx_d = '0;
                  nxt_ped_d = ped_pending ? NXT_PED : ~NXT_PED;
               end
            end
            // zero guard keeps a corrupted counter from parking the FSM in all-red
            S_CLEAR: if (tick && (clr_last || clr_zero)) begin
               if (nxt_ped == NXT_PED) state_d = S_PED;
               else begin
                  state_d = S_GREEN;
                  cur_d   = nxt_idx;
               end
            end
            S_PED: if (ped_done) begin
               state_d   = S_CLEAR;
               nxt_idx_d = '0;
               nxt_ped_d = ~NXT_PED;
            end
            S_SERVICE: begin
               state_d   = S_CLEAR;
               cur_d     = '0;
               nxt_idx_d = '0;
               nxt_ped_d = ~NXT_PED;
            end
            default: begin
               state_d   = S_CLEAR;
               nxt_idx_d = '0;
               nxt_ped_d = ~NXT_PED;
            end
         endcase
      end
   end

   // A press in the same cycle as walk entry survives the entry clear
   assign pend_d   = ped_button | (ped_pending & ~(state_d == S_PED && state != S_PED));
   assign clr_load = (state_d == S_CLEAR) && (state != S_CLEAR);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_GREEN;
         cur         <= '0;
         nxt_idx     <= '0;
         nxt_ped     <= ~NXT_PED;
         ped_pending <= 1'b0;
      end else begin
         state       <= state_d;
         cur         <= cur_d;
         nxt_idx     <= nxt_idx_d;
         nxt_ped     <= nxt_ped_d;
         ped_pending <= pend_d;
      end
   end

   clear_timer #(.W(CNT_W)) u_clear (
      .clk      (clk),
      .rst      (rst),
      .load     (clr_load),
      .load_val (CLR_LEN),
      .tick     (tick && state == S_CLEAR),
      .last     (clr_last),
      .zero     (clr_zero)
   );

   assign phase_idx    = cur;
   assign green        = (state == S_GREEN) ? (ONE << cur) : '0;
   assign ped_green    = (state == S_PED);
   assign all_red      = (state == S_CLEAR);
   assign service_mode = (state == S_SERVICE);
endmodule

// File: tb/tb_phase_sequencer.sv
// Scoreboard bench: two sequencers (4 phases/3-tick clear, 3 phases/1-tick clear)
// driven in lockstep and compared against a behavioural phase model.
module tb_phase_sequencer;
   localparam int K_G = 0, K_C = 1, K_P = 2, K_S = 3;
   localparam int TGT_PED = -1;

   typedef struct {
      int kind; int cur; int tgt; int rem; bit pend;
   } mdl_t;

   typedef struct {
      logic [3:0] g; int idx; bit pg; bit ar; bit sm; bit pp;
   } exp_t;

   logic       clk = 0, rst = 0;
   logic       tick = 0, service = 0, ped_button = 0, ped_done = 0;
   logic [3:0] pd4 = '0;
   logic [2:0] pd3 = '0;
   logic [1:0] idx4, idx3;
   logic [3:0] g4;
   logic [2:0] g3;
   logic       pg4, ar4, sm4, pp4, pg3, ar3, sm3, pp3;

   int   checks = 0, failures = 0;
   mdl_t m4, m3;
   exp_t q4[$], q3[$];

   always #5 clk = ~clk;

   phase_sequencer #(.N_PHASES(4), .CLEAR_TICKS(3), .PH_W(2)) dut4 (
      .clk(clk), .rst(rst), .tick(tick), .service(service), .ped_button(ped_button),
      .phase_done(pd4), .ped_done(ped_done), .phase_idx(idx4), .green(g4),
      .ped_green(pg4), .all_red(ar4), .service_mode(sm4), .ped_pending(pp4));

   phase_sequencer #(.N_PHASES(3), .CLEAR_TICKS(1), .PH_W(2)) dut3 (
      .clk(clk), .rst(rst), .tick(tick), .service(service), .ped_button(ped_button),
      .phase_done(pd3), .ped_done(ped_done), .phase_idx(idx3), .green(g3),
      .ped_green(pg3), .all_red(ar3), .service_mode(sm3), .ped_pending(pp3));

   function automatic mdl_t mreset();
      mdl_t r;
      r.kind = K_G; r.cur = 0; r.tgt = 0; r.rem = 0; r.pend = 0;
      return r;
   endfunction

   // One clock of the intersection rules: what the lights do given this cycle's inputs
   function automatic mdl_t step(mdl_t m, int n, int ct, bit tk, bit sv, bit btn,
                                 logic [3:0] pd, bit pdn);
      mdl_t r = m;
      if (sv) r.kind = K_S;
      else case (m.kind)
         K_G: if (pd[m.cur]) begin
            r.kind = K_C; r.rem = ct;
            r.tgt = (m.cur < n - 1) ? m.cur + 1 : (m.pend ? TGT_PED : 0);
         end
         K_C: if (tk) begin
            r.rem = m.rem - 1;
            if (r.rem == 0) begin
               if (m.tgt == TGT_PED) r.kind = K_P;
               else begin r.kind = K_G; r.cur = m.tgt; end
            end
         end
         K_P: if (pdn) begin r.kind = K_C; r.rem = ct; r.tgt = 0; end
         default: begin r.kind = K_C; r.rem = ct; r.tgt = 0; r.cur = 0; end
      endcase
      r.pend = btn | (m.pend & !(r.kind == K_P && m.kind != K_P));
      return r;
   endfunction

   function automatic exp_t expect_of(mdl_t m);
      exp_t e;
      e.g   = (m.kind == K_G) ? 4'(1 << m.cur) : 4'b0;
      e.idx = m.cur;
      e.pg  = (m.kind == K_P);
      e.ar  = (m.kind == K_C);
      e.sm  = (m.kind == K_S);
      e.pp  = m.pend;
      return e;
   endfunction

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic cyc(bit tk, bit sv, bit btn, logic [3:0] pd, bit pdn);
      @(negedge clk);
      tick = tk; service = sv; ped_button = btn; pd4 = pd; pd3 = pd[2:0]; ped_done = pdn;
      m4 = step(m4, 4, 3, tk, sv, btn, pd, pdn);
      m3 = step(m3, 3, 1, tk, sv, btn, pd, pdn);
      q4.push_back(expect_of(m4));
      q3.push_back(expect_of(m3));
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 0, 4'b0, 0);
   endtask

   // Finish phase p on the 4-phase unit, then walk it through a 3-tick clearance
   task automatic adv(int p);
      cyc(0, 0, 0, 4'(1 << p), 0);
      for (int k = 0; k < 3; k++) begin cyc(1, 0, 0, 4'b0, 0); idle(1); end
   endtask

   task automatic chk_reset_vals(string tag);
      chk({tag, "_g4"},   32'(g4), 32'h1);   chk({tag, "_idx4"}, 32'(idx4), 0);
      chk({tag, "_pg4"},  32'(pg4), 0);      chk({tag, "_ar4"},  32'(ar4), 0);
      chk({tag, "_sm4"},  32'(sm4), 0);      chk({tag, "_pp4"},  32'(pp4), 0);
      chk({tag, "_g3"},   32'(g3), 32'h1);   chk({tag, "_ar3"},  32'(ar3), 0);
   endtask

   task automatic mid_reset();
      @(negedge clk);
      tick = 0; service = 0; ped_button = 0; pd4 = '0; pd3 = '0; ped_done = 0;
      #1 rst = 0;
      #1 chk_reset_vals("midrst");
      m4 = mreset(); m3 = mreset();
      @(negedge clk) rst = 1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (q4.size() > 0) begin
            e = q4.pop_front();
            chk("n4_green", 32'(g4), 32'(e.g));      chk("n4_idx", 32'(idx4), 32'(e.idx));
            chk("n4_ped_green", 32'(pg4), 32'(e.pg)); chk("n4_all_red", 32'(ar4), 32'(e.ar));
            chk("n4_service", 32'(sm4), 32'(e.sm));  chk("n4_pending", 32'(pp4), 32'(e.pp));
         end
         if (q3.size() > 0) begin
            e = q3.pop_front();
            chk("n3_green", 32'(g3), 32'(e.g[2:0])); chk("n3_idx", 32'(idx3), 32'(e.idx));
            chk("n3_ped_green", 32'(pg3), 32'(e.pg)); chk("n3_all_red", 32'(ar3), 32'(e.ar));
            chk("n3_service", 32'(sm3), 32'(e.sm));  chk("n3_pending", 32'(pp3), 32'(e.pp));
         end
      end
   end

   initial begin : stim
      bit sv_lvl;
      m4 = mreset(); m3 = mreset();
      repeat (2) @(negedge clk);
      chk_reset_vals("reset");
      @(negedge clk) rst = 1;
      idle(3);

      for (int p = 0; p < 4; p++) adv(p);            // full rotation, no walk

      adv(0);
      cyc(0, 0, 1, 4'b0, 0);                         // press during phase 1
      adv(1); adv(2); adv(3);                        // last phase goes to walk
      idle(2);
      cyc(0, 0, 0, 4'b0, 1);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 4'b0, 0);

      adv(0); adv(1);
      cyc(1, 1, 0, 4'b0100, 0);                      // service beats done on phase 2
      idle(0); cyc(0, 1, 0, 4'b0, 0); cyc(1, 1, 0, 4'b0, 0);
      for (int k = 0; k < 4; k++) begin cyc(1, 0, 0, 4'b0, 0); idle(1); end

      adv(0);
      cyc(0, 0, 0, 4'b1000, 0);                      // foreign done bit ignored
      cyc(0, 0, 0, 4'b0010, 0);
      cyc(1, 0, 0, 4'b0, 0);
      mid_reset();
      idle(2);

      // walk entry coinciding with a new press keeps the request latched
      adv(0); adv(1); cyc(0, 0, 1, 4'b0, 0); adv(2);
      cyc(0, 0, 0, 4'b1000, 0); cyc(1, 0, 0, 4'b0, 0); cyc(1, 0, 0, 4'b0, 0);
      cyc(1, 0, 1, 4'b0, 0);
      idle(2); cyc(0, 0, 0, 4'b0, 1);

      sv_lvl = 0;
      for (int i = 0; i < 4000; i++) begin
         if (sv_lvl) sv_lvl = ($urandom_range(0, 3) != 0);
         else        sv_lvl = ($urandom_range(0, 59) == 0);
         cyc($urandom_range(0, 2) == 0, sv_lvl, $urandom_range(0, 19) == 0,
             4'($urandom_range(0, 15) & $urandom_range(0, 15)),
             $urandom_range(0, 5) == 0);
         if (i == 2000) mid_reset();
      end

      idle(2);
      @(posedge clk); #3;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
